// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift on
// device falling edges, ACK check, timeout; open-drain line enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 800,
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_inhibit,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          c_filt;
  logic [FW-1:0] fcnt;
  logic          fe;

  logic [7:0]    shreg;
  logic          par;
  logic [3:0]    bitcnt;
  logic          dout;
  logic          ack_ok;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          done_q, err_q;

  logic accept, inh_last, active, to_hit, bus_idle;

  // Sync flops idle high so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c_i;
      c_s2 <= c_s1;
      d_s1 <= ps2d_i;
      d_s2 <= d_s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_filt <= 1'b1;
      fcnt   <= '0;
    end else if (c_s2 == c_filt) begin
      fcnt <= '0;
    end else if (fcnt == FLT_LAST) begin
      c_filt <= c_s2;
      fcnt   <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign fe = c_filt & ~c_s2 & (fcnt == FLT_LAST);

  // A request landing on the done/err cycle is dropped on purpose.
  assign accept   = (state == S_IDLE) & tx_start & ~done_q & ~err_q;
  assign inh_last = (inh_cnt == INH_LAST);
  assign active   = (state == S_REQ) | (state == S_SHIFT) |
                    (state == S_ACK) | (state == S_WAIT);
  assign to_hit   = active & ~fe & (to_cnt == TO_LAST);
  assign bus_idle = c_filt & d_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (accept) state_nxt = S_INHIBIT;
      S_INHIBIT:
        if (inh_last) state_nxt = S_REQ;
      S_REQ:
        if (to_hit)  state_nxt = S_IDLE;
        else if (fe) state_nxt = S_SHIFT;
      S_SHIFT:
        if (to_hit)                       state_nxt = S_IDLE;
        else if (fe && bitcnt == 4'd9)    state_nxt = S_ACK;
      S_ACK:
        if (to_hit)  state_nxt = S_IDLE;
        else if (fe) state_nxt = S_WAIT;
      S_WAIT:
        if (to_hit || bus_idle) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg   <= '0;
      par     <= 1'b0;
      bitcnt  <= '0;
      dout    <= 1'b0;
      ack_ok  <= 1'b0;
      inh_cnt <= '0;
      to_cnt  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (active) to_cnt <= fe ? '0 : to_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg   <= tx_data;
            par     <= ~^tx_data;
            bitcnt  <= '0;
            inh_cnt <= '0;
            dout    <= 1'b0;
          end
        end
        S_INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_last) begin
            dout   <= 1'b1;
            to_cnt <= '0;
          end
        end
        S_REQ: begin
          if (to_hit) begin
            dout  <= 1'b0;
            err_q <= 1'b1;
          end else if (fe) begin
            dout   <= ~shreg[0];
            bitcnt <= 4'd1;
          end
        end
        S_SHIFT: begin
          if (to_hit) begin
            dout  <= 1'b0;
            err_q <= 1'b1;
          end else if (fe) begin
            unique case (1'b1)
              (bitcnt < 4'd8): begin
                dout   <= ~shreg[bitcnt[2:0]];
                bitcnt <= bitcnt + 1'b1;
              end
              (bitcnt == 4'd8): begin
                dout   <= ~par;
                bitcnt <= 4'd9;
              end
              default: begin
                dout   <= 1'b0;
                bitcnt <= 4'd10;
              end
            endcase
          end
        end
        S_ACK: begin
          if (to_hit)  err_q  <= 1'b1;
          else if (fe) ack_ok <= ~d_s2;
        end
        S_WAIT: begin
          if (to_hit) begin
            err_q <= 1'b1;
          end else if (bus_idle) begin
            done_q <= ack_ok;
            err_q  <= ~ack_ok;
          end
        end
        default: dout <= 1'b0;
      endcase
    end
  end

  always_comb begin
    ps2c_oe    = (state == S_INHIBIT);
    ps2d_oe    = dout;
    tx_busy    = (state != S_IDLE);
    rx_inhibit = (state != S_IDLE);
    tx_done    = done_q;
    tx_err     = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a bus-level device model
// that clocks frames, samples bits on rising edges and ACKs.
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int TO  = 3000;
  localparam int FL  = 8;
  localparam int HP  = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err, rx_inhibit;
  logic       ps2c_i, ps2d_i, ps2c_oe, ps2d_oe;
  logic       dev_c = 1'b0;
  logic       dev_d = 1'b0;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign ps2c_i = ~(ps2c_oe | dev_c);
  assign ps2d_i = ~(ps2d_oe | dev_d);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .rx_inhibit(rx_inhibit),
    .ps2c_i(ps2c_i),
    .ps2d_i(ps2d_i),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err)  err_cnt  <= err_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [7:0] b, output int n);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    n = 0;
    while (ps2c_oe && n < 4 * INH) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic frame(input string tag, input logic [10:0] exp,
                       input bit ack, input bit glitch,
                       input bit poke, input int abort_fe);
    logic [10:0] got;
    int n, d0, e0;
    got = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    req(exp[8:1], n);
    chk({tag, " inhibit_len"}, n, INH);
    chk({tag, " req_data"}, 32'(ps2d_oe), 32'd1);
    chk({tag, " req_clk"}, 32'(ps2c_oe), 32'd0);
    repeat (HP) @(negedge clk);
    got[0] = ps2d_i;
    for (int i = 1; i <= 10; i++) begin
      dev_c = 1'b1;
      if (poke && i == 5) begin
        @(negedge clk);
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (HP - 2) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      dev_c = 1'b0;
      if (glitch) begin
        repeat (15) @(negedge clk);
        dev_c = 1'b1;
        repeat (3) @(negedge clk);
        dev_c = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (HP / 2) @(negedge clk);
      end
      got[i] = ps2d_i;
      if (i == abort_fe) begin
        chk({tag, " pre_rst_data"}, 32'(ps2d_oe), 32'd1);
        chk({tag, " pre_rst_busy"}, 32'(tx_busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk({tag, " rst_clk_oe"}, 32'(ps2c_oe), 32'd0);
        chk({tag, " rst_data_oe"}, 32'(ps2d_oe), 32'd0);
        chk({tag, " rst_busy"}, 32'(tx_busy), 32'd0);
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (HP) @(negedge clk);
        chk({tag, " rst_done"}, done_cnt - d0, 0);
        chk({tag, " rst_err"}, err_cnt - e0, 0);
        return;
      end
      repeat (HP / 2) @(negedge clk);
    end
    if (ack) dev_d = 1'b1;
    repeat (HP / 2) @(negedge clk);
    dev_c = 1'b1;
    repeat (HP) @(negedge clk);
    dev_c = 1'b0;
    repeat (HP / 2) @(negedge clk);
    dev_d = 1'b0;
    n = 0;
    while (tx_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " busy_end"}, 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, " frame_bits"}, 32'(got), 32'(exp));
    chk({tag, " done_pulses"}, done_cnt - d0, ack ? 1 : 0);
    chk({tag, " err_pulses"}, err_cnt - e0, ack ? 0 : 1);
    chk({tag, " clk_oe_end"}, 32'(ps2c_oe), 32'd0);
    chk({tag, " data_oe_end"}, 32'(ps2d_oe), 32'd0);
  endtask

  initial begin
    int n, d0, e0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(tx_busy), 32'd0);
    chk("rst done", 32'(tx_done), 32'd0);
    chk("rst err", 32'(tx_err), 32'd0);
    chk("rst inhibit", 32'(rx_inhibit), 32'd0);
    chk("rst clk_oe", 32'(ps2c_oe), 32'd0);
    chk("rst data_oe", 32'(ps2d_oe), 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    frame("ed", {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1, 1'b0, 1'b0, 0);
    frame("01", {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1, 1'b0, 1'b0, 0);
    frame("ff", {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1, 1'b0, 1'b0, 0);
    frame("00", {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 1'b0, 1'b0, 0);
    frame("nack", {1'b1, 1'b1, 8'h0F, 1'b0}, 1'b0, 1'b0, 1'b0, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    req(8'hED, n);
    chk("to inhibit_len", n, INH);
    n = 0;
    while (tx_busy && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("to cycles", n, TO);
    repeat (3) @(negedge clk);
    chk("to err", err_cnt - e0, 1);
    chk("to done", done_cnt - d0, 0);
    chk("to clk_oe", 32'(ps2c_oe), 32'd0);
    chk("to data_oe", 32'(ps2d_oe), 32'd0);
    chk("to busy", 32'(tx_busy), 32'd0);

    frame("glitch", {1'b1, 1'b1, 8'h5A, 1'b0}, 1'b1, 1'b1, 1'b1, 0);
    frame("abort", {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 1'b0, 1'b0, 6);
    frame("f4", {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b1, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
